// File: rtl/icache.sv
// ---------------------------------------------------------------------------
// icache: read-only, direct-mapped instruction cache holding 16 lines of
// 4 words each (256 bytes).
// A lookup hit is combinational from pc in the IDLE state. On a miss the
// whole line is fetched from word 0 upward, one word per memack. While the
// fill runs, hit stays low so the fetch stage stalls.
//
// Ports
//   clk        : clock, rising-edge active
//   reset      : asynchronous, active-high reset
//   pc         : fetch address; pc[1:0] is ignored
//   instr      : instruction word for pc; 0 (nop) whenever hit=0
//   hit        : 1 = instr is valid this cycle, 0 = fetch stage stalls
//   invalidate : clears all valid bits on the edge where it is high
//   memreq     : line-fill word request to main memory
//   memadr     : word-aligned byte address of the requested word
//   memrdata   : word returned by memory, used only when memack=1
//   memack     : 1 = memrdata holds the word for memadr
// ---------------------------------------------------------------------------
module icache (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  output logic        hit,
  input  logic        invalidate,
  output logic        memreq,
  output logic [31:0] memadr,
  input  logic [31:0] memrdata,
  input  logic        memack
);

  typedef enum logic {IDLE, FILL} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] fill_tag_q, fill_tag_d;
  logic [3:0]  fill_idx_q, fill_idx_d;
  logic        abort_q, abort_d;
  logic [15:0] valid_q, valid_d;

  // The tag and data arrays are not reset. The valid bits alone decide
  // whether their contents are used.
  logic [23:0] tag_arr  [16];
  logic [31:0] data_arr [64];

  logic [23:0] pc_tag;
  logic [3:0]  pc_idx;
  logic [1:0]  pc_off;
  logic        lookup_hit;
  logic        data_we;
  logic        fill_done;
  logic        unused_pc_bits;

  assign pc_tag = pc[31:8];
  assign pc_idx = pc[7:4];
  assign pc_off = pc[3:2];
  assign unused_pc_bits = ^pc[1:0];

  assign lookup_hit = valid_q[pc_idx] && (tag_arr[pc_idx] == pc_tag);
  assign data_we    = (state_q == FILL) && memack;
  assign fill_done  = data_we && (cnt_q == 2'd3);

  // State register and fill bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      abort_q    <= 1'b0;
      valid_q    <= 16'h0000;
      fill_tag_q <= 24'h000000;
      fill_idx_q <= 4'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      abort_q    <= abort_d;
      valid_q    <= valid_d;
      fill_tag_q <= fill_tag_d;
      fill_idx_q <= fill_idx_d;
    end
  end

  // Array writes: each acked word goes in. The tag is written on the last
  // word even for an aborted fill, because its valid bit stays clear.
  always_ff @(posedge clk) begin
    if (data_we) begin
      data_arr[{fill_idx_q, cnt_q}] <= memrdata;
    end
    if (fill_done) begin
      tag_arr[fill_idx_q] <= fill_tag_q;
    end
  end

  // Next-state logic. When invalidate is high, a miss in IDLE does not start
  // a fill.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!lookup_hit && !invalidate) state_d = FILL;
      FILL: if (fill_done)                  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values.
  // The abort flag records any invalidate seen during a fill, so that a line
  // fetched across an invalidate is never marked valid.
  // The invalidate clear is applied last, so it wins over a set made on the
  // same edge.
  always_comb begin
    cnt_d      = cnt_q;
    fill_tag_d = fill_tag_q;
    fill_idx_d = fill_idx_q;
    abort_d    = abort_q;
    valid_d    = valid_q;
    if (state_q == IDLE) begin
      abort_d = 1'b0;
      if (!lookup_hit && !invalidate) begin
        fill_tag_d = pc_tag;
        fill_idx_d = pc_idx;
        cnt_d      = 2'd0;
      end
    end else begin
      if (invalidate) abort_d = 1'b1;
      if (memack)     cnt_d   = cnt_q + 2'd1;
      if (fill_done) begin
        abort_d = 1'b0;
        if (!abort_q && !invalidate) valid_d[fill_idx_q] = 1'b1;
      end
    end
    if (invalidate) valid_d = 16'h0000;
  end

  // Outputs. Reset forces state_q to IDLE asynchronously, so memreq drops at
  // once. Reset also clears valid_q, so hit drops at once as well.
  always_comb begin
    hit    = (state_q == IDLE) && lookup_hit;
    instr  = hit ? data_arr[{pc_idx, pc_off}] : 32'h00000000;
    memreq = (state_q == FILL);
    memadr = memreq ? {fill_tag_q, fill_idx_q, cnt_q, 2'b00} : 32'h00000000;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter: none; geometry fixed at 16 lines x 4 words (256 bytes), direct-mapped.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 pc  input  32  fetch address from the core fetch stage; pc[1:0] ignored.
REQ-005 instr  output  32  instruction word for pc; valid only when hit=1.
REQ-006 hit  output  1  1 = instr valid this cycle; 0 = core fetch stage shall stall.
REQ-007 invalidate  input  1  1 for one or more cycles = clear all valid bits.
REQ-008 memreq  output  1  line-fill word request to main memory.
REQ-009 memadr  output  32  byte address of requested word, word-aligned.
REQ-010 memrdata  input  32  returned word; sampled only when memack=1.
REQ-011 memack  input  1  1 = memrdata holds the word for the current memadr.

Function
REQ-012 Address split: offset = pc[3:2], index = pc[7:4], tag = pc[31:8] (24 bits).
REQ-013 Storage: per line one valid bit, one 24-bit tag, four 32-bit data words.
REQ-014 States: IDLE, FILL; no other states.
REQ-015 IDLE: hit = valid[index] & (tag_array[index] == tag), combinational from pc, zero-cycle latency.
REQ-016 instr = data[index][offset] when hit=1; instr = 32'h00000000 (nop) when hit=0.
REQ-017 IDLE with hit=0 and invalidate=0: latch fill tag/index from pc, clear word counter to 0, enter FILL on next edge.
REQ-018 FILL: memreq=1, hit=0; memadr = {fill tag, fill index, counter, 2'b00}; fill always starts at word 0 of the line.
REQ-019 FILL, memack=1: write memrdata to data[fill index][counter], counter increments (2-bit) on same edge.
REQ-020 FILL, memack=1 with counter=3: write fill tag, set valid[fill index] (unless REQ-023), return to IDLE; memreq=0 next cycle.
REQ-021 FILL, memack=0: hold state, counter, memadr; memreq stays 1.
REQ-022 pc changes during FILL are ignored; fill completes for the latched address; lookup resumes with current pc in IDLE.
REQ-023 invalidate=1 in any cycle: all valid bits cleared on that edge; if FILL is active, the filling line shall not be marked valid at completion (sticky abort flag, cleared on entry to IDLE).
REQ-024 invalidate=1 in IDLE suppresses fill start that cycle; hit computed from pre-clear valid bits that cycle.
REQ-025 Miss penalty with memack held 1: miss seen cycle 0, memreq cycles 1-4, hit=1 in cycle 5 for unchanged pc.
REQ-026 A completed fill overwrites the prior line at that index regardless of prior tag (no write-back; read-only cache).

Reset
REQ-027 reset=1: state IDLE, counter 0, abort flag 0, all 16 valid bits 0, asynchronously.
REQ-028 Outputs during/after reset: memreq=0, hit=0, instr=0, memadr=don't-care; tag/data arrays not reset.
REQ-029 reset mid-FILL: fill abandoned immediately, memreq drops asynchronously, no line marked valid.

Verification
REQ-030 Cold miss: reset, pc=0x00400000, memack=1, memrdata=0x20080005,0x20090007,0x01095020,0xAC0A0000 -> memadr 0x00400000,04,08,0C in cycles 1-4; hit=1 cycle 5, instr=0x20080005; pc=0x0040000C then hits with 0xAC0A0000.
REQ-031 Conflict: after REQ-030, pc=0x00400100 (same index 0, tag differs) -> hit=0, fill of 0x00400100-10C; then pc=0x00400000 misses again.
REQ-032 Slow memory: memack=1 only every third cycle -> memadr holds each word until ack, memreq stays 1, hit=1 exactly one cycle after 4th ack.
REQ-033 Invalidate: after valid line, invalidate=1 one cycle -> same pc hit=0 next cycle; invalidate during FILL -> fill completes, memreq drops, line re-fetched (hit=0, new FILL).
REQ-034 Reset mid-fill: assert reset after 2nd ack -> memreq=0 same cycle; after release pc of that line misses and refills from word 0.
REQ-035 pc change in FILL: pc switches 0x00400000 -> 0x00400040 mid-fill -> fill finishes for 0x00400000, then second fill for index 4.
